mem_port_arbiter: RTL

//  Shares the single main-memory port between the instruction-cache refill path and the data load/store path.

---
 rtl/mem_arb_pkg.sv | 11 +
 rtl/mem_arb_starve_counter.sv | 20 ++
 rtl/mem_port_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM state encoding and owner codes for the memory port arbiter
package mem_arb_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;
    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_INST = 2'b01;
    localparam logic [1:0] OWN_DATA = 2'b10;
endpackage

// File: rtl/mem_arb_starve_counter.sv
// mem_arb_starve_counter: saturating up-counter flagging when it reaches LIMIT
//  clk, reset (async active-low), inc (count up, saturates at LIMIT),
//  clr (return to 0, wins over inc), at_limit (count equals LIMIT)
module mem_arb_starve_counter #(
    parameter int LIMIT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);
    localparam int W = $clog2(LIMIT + 1);
    logic [W-1:0] cnt_q, cnt_d;
    assign at_limit = cnt_q == W'(LIMIT);
    always_comb cnt_d = clr ? '0 : (inc && !at_limit) ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk or negedge reset)
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction refill and data load/store
//  Ports: clk, reset (async active-low)
//   i_req/i_addr -> i_valid/i_rdata : instruction refill (read-only, mem_be forced to 4'hF)
//   d_req/d_we/d_addr/d_wdata/d_be -> d_valid/d_rdata : data load/store
//   mem_addr/mem_ren/mem_wen/mem_wdata/mem_be -> memory, mem_rdata/mem_ready <- memory
//   owner : 00 none, 01 instruction, 10 data; err : watchdog abort pulse
//  Build option ARB_TIMEOUT_EN adds a mem_ready watchdog (TIMEOUT_CYC); without it err is 0.
module mem_port_arbiter import mem_arb_pkg::*; #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 8
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC  = 64
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_valid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [3:0]        d_be,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_ren,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_be,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [1:0]        owner,
    output logic              err
);
    state_t            state_q, state_d;
    logic [1:0]        win_q, win_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              starved, grant_i, decide, timeout, done;
    logic [DATA_W-1:0] rd_val;

    // Data normally wins; a starved instruction request takes the grant instead.
    assign decide  = state_q == IDLE && (i_req || d_req);
    assign grant_i = i_req && (!d_req || starved);

    mem_arb_starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
        .clk      (clk),
        .reset    (reset),
        .inc      (decide && i_req && !grant_i),
        .clr      (decide && grant_i),
        .at_limit (starved)
    );

`ifdef ARB_TIMEOUT_EN
    logic wd_limit;
    logic err_q;
    // Limit is one less than TIMEOUT_CYC: the abort fires on the edge closing the last allowed BUSY cycle.
    mem_arb_starve_counter #(.LIMIT(TIMEOUT_CYC - 1)) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .inc      (state_q == BUSY),
        .clr      (state_q != BUSY),
        .at_limit (wd_limit)
    );
    assign timeout = state_q == BUSY && !mem_ready && wd_limit;
    assign err     = err_q;
    always_ff @(posedge clk or negedge reset)
        if (!reset) err_q <= 1'b0;
        else        err_q <= timeout;
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    assign done   = state_q == BUSY && (mem_ready || timeout);
    assign rd_val = mem_ready ? mem_rdata : '0;

    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        if (decide) begin
            state_d = BUSY;
            win_d   = grant_i ? OWN_INST : OWN_DATA;
            addr_d  = grant_i ? i_addr : d_addr;
            we_d    = !grant_i && d_we;
            wdata_d = grant_i ? '0 : d_wdata;
            be_d    = grant_i ? 4'hF : d_be;
        end
        if (done) begin
            state_d = RESP;
            // Completed writes leave d_rdata alone; an aborted access returns zero.
            if (win_q == OWN_INST) i_rdata_d = rd_val;
            else if (!we_q || !mem_ready) d_rdata_d = rd_val;
        end
        if (state_q == RESP) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state_q   <= IDLE;
            win_q     <= OWN_NONE;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            be_q      <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end

    // Enables decode from the state register so they drop the instant reset asserts.
    assign mem_ren   = state_q == BUSY && !we_q;
    assign mem_wen   = state_q == BUSY && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_be    = be_q;
    assign owner     = state_q == IDLE ? OWN_NONE : win_q;
    assign i_valid   = state_q == RESP && win_q == OWN_INST;
    assign d_valid   = state_q == RESP && win_q == OWN_DATA;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
endmodule
